// File: rtl/crc32_seq_pkg.sv
// Shared types and helpers for the CRC-32 frame sequencer and its word serializer.
package crc32_seq_pkg;

    localparam int unsigned CRC_W = 32;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoad,
        StShift,
        StWait,
        StDone
    } seq_state_e;

    // Byte count of an accepted word; s_bytes only matters on the final word.
    function automatic logic [2:0] bytes_decode(input logic last, input logic [1:0] nbytes);
        if (!last || nbytes == 2'd0) begin
            return 3'd4;
        end
        return {1'b0, nbytes};
    endfunction

endpackage

// File: rtl/crc32_frame_sequencer_if.sv
// Word stream from the frame builder into the CRC sequencer.
interface crc32_frame_sequencer_if;
    import crc32_seq_pkg::*;

    logic             s_valid;
    logic             s_ready;
    logic [CRC_W-1:0] s_data;
    logic             s_last;
    logic [1:0]       s_bytes;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        output s_bytes,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        input  s_bytes,
        output s_ready
    );

endinterface

// File: rtl/crc32_word_serializer.sv
// Holds one accepted word and shifts it out MSB-first, tracking the remaining bit count.
module crc32_word_serializer
    import crc32_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [CRC_W-1:0] data,
    input  logic [2:0]       nbytes,
    input  logic             last,
    output logic             msb,
    output logic             bit_last,
    output logic             frame_last
);

    logic [CRC_W-1:0] shreg_q;
    logic [4:0]       bitcnt_q;
    logic             last_q;
    logic [4:0]       load_cnt;

    // nbytes is 1..4, so 8*nbytes-1 always fits in five bits.
    assign load_cnt = 5'({nbytes, 3'b000} - 6'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q  <= '0;
            bitcnt_q <= '0;
            last_q   <= 1'b0;
        end else if (load) begin
            shreg_q  <= data;
            bitcnt_q <= load_cnt;
            last_q   <= last;
        end else if (shift) begin
            shreg_q  <= {shreg_q[CRC_W-2:0], 1'b0};
            bitcnt_q <= bitcnt_q - 5'd1;
        end
    end

    assign msb        = shreg_q[CRC_W-1];
    assign bit_last   = (bitcnt_q == 5'd0);
    assign frame_last = last_q;

endmodule

// File: rtl/crc32_frame_sequencer.sv
// Feeds framed 32-bit words bit-serially into the CRC-32 core and latches the frame CRC.
module crc32_frame_sequencer
    import crc32_seq_pkg::*;
#(
    parameter bit          FINAL_XOR  = 1'b0,
    parameter int unsigned BYTE_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    crc32_frame_sequencer_if.slave  stream,
    input  logic                    abort,
    output logic                    crc_clear,
    output logic                    crc_bit,
    output logic                    crc_valid,
    input  logic [CRC_W-1:0]        crc_in,
    output logic                    busy,
    output logic                    done,
    output logic [CRC_W-1:0]        crc_out,
    output logic [BYTE_CNT_W-1:0]   byte_count
);

    localparam int unsigned SumW = BYTE_CNT_W + 1;

    seq_state_e             state_q, state_d;
    logic                   handshake;
    logic [2:0]             nbytes;
    logic                   msb, bit_last, frame_last;
    logic [BYTE_CNT_W-1:0]  run_cnt_q;
    logic [SumW-1:0]        run_sum;
    logic [CRC_W-1:0]       crc_out_q;
    logic [BYTE_CNT_W-1:0]  byte_count_q;
    logic                   done_q;

    assign nbytes    = bytes_decode(stream.s_last, stream.s_bytes);
    assign handshake = stream.s_valid && stream.s_ready;
    assign run_sum   = {1'b0, run_cnt_q} + SumW'(nbytes);

    crc32_word_serializer u_serializer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (handshake),
        .shift      (state_q == StShift),
        .data       (stream.s_data),
        .nbytes     (nbytes),
        .last       (stream.s_last),
        .msb        (msb),
        .bit_last   (bit_last),
        .frame_last (frame_last)
    );

    always_comb begin
        state_d        = state_q;
        stream.s_ready = (state_q == StLoad) && !abort;
        crc_clear      = (state_q == StClear);
        crc_valid      = (state_q == StShift);
        crc_bit        = (state_q == StShift) && msb;
        busy           = (state_q != StIdle);

        unique case (state_q)
            StIdle:  if (stream.s_valid) state_d = StClear;
            StClear: state_d = StLoad;
            StLoad:  if (handshake) state_d = StShift;
            StShift: if (bit_last) state_d = frame_last ? StWait : StLoad;
            StWait:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (abort && state_q != StIdle) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            run_cnt_q    <= '0;
            crc_out_q    <= '0;
            byte_count_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (state_q == StClear) begin
                run_cnt_q <= '0;
            end else if (handshake) begin
                run_cnt_q <= run_sum[BYTE_CNT_W] ? '1 : run_sum[BYTE_CNT_W-1:0];
            end
            // The core's CRC settles one edge after the last bit, i.e. during WAIT.
            if (state_q == StWait && !abort) begin
                crc_out_q    <= crc_in ^ {CRC_W{FINAL_XOR}};
                byte_count_q <= run_cnt_q;
                done_q       <= 1'b1;
            end
        end
    end

    assign done       = done_q;
    assign crc_out    = crc_out_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_crc32_frame_sequencer.sv
// Directed bench for crc32_frame_sequencer with a bit-serial CRC-32 core model.
module tb_crc32_frame_sequencer;
    import crc32_seq_pkg::*;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        abort = 1'b0;
    logic        crc_clear, crc_bit, crc_valid, busy, done;
    logic [31:0] crc_in, crc_out;
    logic [31:0] core_q = '0;
    logic        core_force = 1'b0;
    logic [15:0] byte_count;

    int n_tests = 0;
    int n_fail = 0;

    crc32_frame_sequencer_if bus ();

    crc32_frame_sequencer #(
        .FINAL_XOR  (1'b1),
        .BYTE_CNT_W (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stream     (bus),
        .abort      (abort),
        .crc_clear  (crc_clear),
        .crc_bit    (crc_bit),
        .crc_valid  (crc_valid),
        .crc_in     (crc_in),
        .busy       (busy),
        .done       (done),
        .crc_out    (crc_out),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    // Core model: MSB-first LFSR, preset to all ones on clear.
    always @(posedge clk) begin
        if (crc_clear) core_q <= 32'hFFFFFFFF;
        else if (crc_valid) core_q <= {core_q[30:0], 1'b0} ^ ((core_q[31] ^ crc_bit) ? POLY : 32'h0);
    end
    assign crc_in = core_force ? 32'h12345678 : core_q;

    int          cyc = 0;
    int          clear_cnt = 0, valid_cnt = 0, rise_cnt = 0, done_cnt = 0;
    int          last_clear_cyc = 0, last_rise_cyc = 0, last_valid_cyc = 0, done_cyc = 0;
    logic [63:0] bit_acc = '0;
    logic        prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (crc_clear) begin
            clear_cnt      <= clear_cnt + 1;
            last_clear_cyc <= cyc;
        end
        if (crc_valid) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
            bit_acc        <= {bit_acc[62:0], crc_bit};
            if (!prev_valid) begin
                rise_cnt      <= rise_cnt + 1;
                last_rise_cyc <= cyc;
            end
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        prev_valid <= crc_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, required below %0d", cyc, 50000);
        $fatal(1);
    end

    logic [31:0] words[$];
    int          s_clear, s_valid_c, s_rise, s_done, t0, gap_bad;
    logic [31:0] ref_crc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_ref(input int n);
        logic [31:0] c;
        logic [31:0] w;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++) begin
            w = words[k/4];
            b = w[31-8*(k%4) -: 8];
            c = c ^ {b, 24'h0};
            for (int j = 0; j < 8; j++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
        end
        return ~c;
    endfunction

    task automatic snap();
        s_clear   = clear_cnt;
        s_valid_c = valid_cnt;
        s_rise    = rise_cnt;
        s_done    = done_cnt;
    endtask

    // Returns at the negedge after the accepting edge (first SHIFT cycle).
    task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] nb);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        bus.s_bytes = nb;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (bus.s_ready) begin
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        check_eq("handshake_timeout", 64'(bus.s_ready), 64'd1);
    endtask

    task automatic wait_load();
        for (int i = 0; i < 40; i++) begin
            if (!crc_valid) return;
            @(negedge clk);
        end
        check_eq("load_timeout", 64'(crc_valid), 64'd0);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                @(negedge clk);
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        check_eq("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic send_frame(input int n, input logic [1:0] last_nb, input bit gaps);
        for (int i = 0; i < n; i++) begin
            send_word(words[i], i == n - 1, (i == n - 1) ? last_nb : 2'd0);
            if (i == n - 1) begin
                bus.s_valid = 1'b0;
            end else if (gaps) begin
                bus.s_valid = 1'b0;
                wait_load();
                for (int k = 0; k < 5; k++) begin
                    if (crc_valid || !busy) gap_bad++;
                    @(negedge clk);
                end
            end
        end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.s_bytes = 2'd0;
        gap_bad     = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_strobes", 64'({crc_clear, crc_valid, crc_bit, done, bus.s_ready}), 64'd0);
        check_eq("rst_crc_out", 64'(crc_out), 64'd0);
        check_eq("rst_byte_count", 64'(byte_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single full word: timing and bit order.
        words = {32'hB888E3A7};
        snap();
        t0 = cyc;
        send_frame(1, 2'd0, 1'b0);
        wait_done(100);
        check_eq("t1_clear_cnt", 64'(clear_cnt - s_clear), 64'd1);
        check_eq("t1_clear_at", 64'(last_clear_cyc - t0), 64'd1);
        check_eq("t1_valid_cnt", 64'(valid_cnt - s_valid_c), 64'd32);
        check_eq("t1_valid_first", 64'(last_rise_cyc - t0), 64'd3);
        check_eq("t1_valid_last", 64'(last_valid_cyc - t0), 64'd34);
        check_eq("t1_bits", 64'(bit_acc[31:0]), 64'h0000_0000_B888_E3A7);
        check_eq("t1_done_cnt", 64'(done_cnt - s_done), 64'd1);
        check_eq("t1_done_at", 64'(done_cyc - t0), 64'd36);
        check_eq("t1_byte_count", 64'(byte_count), 64'd4);
        check_eq("t1_crc", 64'(crc_out), 64'(crc_ref(4)));

        // Partial last word with a fixed core value.
        core_force = 1'b1;
        words = {32'h04020000};
        snap();
        send_frame(1, 2'd2, 1'b0);
        wait_done(100);
        check_eq("t2_valid_cnt", 64'(valid_cnt - s_valid_c), 64'd16);
        check_eq("t2_bits", 64'(bit_acc[15:0]), 64'h0402);
        check_eq("t2_crc", 64'(crc_out), 64'hEDCB_A987);
        check_eq("t2_byte_count", 64'(byte_count), 64'd2);
        core_force = 1'b0;

        // 16 full words plus a 2-byte tail, back to back.
        words = {};
        for (int i = 0; i < 16; i++) words.push_back(32'h01020304 + 32'(i) * 32'h04040404);
        words.push_back(32'h04020000);
        ref_crc = crc_ref(66);
        snap();
        send_frame(17, 2'd2, 1'b0);
        wait_done(1000);
        check_eq("t3_valid_cnt", 64'(valid_cnt - s_valid_c), 64'd528);
        check_eq("t3_valid_bursts", 64'(rise_cnt - s_rise), 64'd17);
        check_eq("t3_byte_count", 64'(byte_count), 64'd66);
        check_eq("t3_crc", 64'(crc_out), 64'(ref_crc));

        // Same frame with 5-cycle stalls in LOAD.
        snap();
        send_frame(17, 2'd2, 1'b1);
        wait_done(2000);
        check_eq("t4_gap_hold", 64'(gap_bad), 64'd0);
        check_eq("t4_valid_cnt", 64'(valid_cnt - s_valid_c), 64'd528);
        check_eq("t4_crc", 64'(crc_out), 64'(ref_crc));

        // Abort in LOAD racing a valid word.
        snap();
        send_word(32'hDEADBEEF, 1'b0, 2'd0);
        bus.s_valid = 1'b0;
        wait_load();
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hCAFEF00D;
        bus.s_last  = 1'b1;
        abort       = 1'b1;
        #1;
        check_eq("t5a_ready_blocked", 64'(bus.s_ready), 64'd0);
        @(negedge clk);
        abort       = 1'b0;
        bus.s_valid = 1'b0;
        check_eq("t5a_idle", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        check_eq("t5a_valid_cnt", 64'(valid_cnt - s_valid_c), 64'd32);
        check_eq("t5a_no_done", 64'(done_cnt - s_done), 64'd0);
        check_eq("t5a_crc_kept", 64'(crc_out), 64'(ref_crc));
        check_eq("t5a_bytes_kept", 64'(byte_count), 64'd66);

        // Abort mid-SHIFT.
        snap();
        send_word(32'h55AA55AA, 1'b1, 2'd0);
        bus.s_valid = 1'b0;
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("t5b_idle", 64'({busy, crc_valid}), 64'd0);
        repeat (40) @(negedge clk);
        check_eq("t5b_valid_cnt", 64'(valid_cnt - s_valid_c), 64'd11);
        check_eq("t5b_no_done", 64'(done_cnt - s_done), 64'd0);
        check_eq("t5b_crc_kept", 64'(crc_out), 64'(ref_crc));

        // Following frame "123456789": CRC-32/BZIP2 check value.
        words = {32'h31323334, 32'h35363738, 32'h39000000};
        send_frame(3, 2'd1, 1'b0);
        wait_done(200);
        check_eq("t5c_crc", 64'(crc_out), 64'hFC89_1918);
        check_eq("t5c_byte_count", 64'(byte_count), 64'd9);

        // Reset mid-SHIFT.
        send_word(32'hB888E3A7, 1'b1, 2'd0);
        bus.s_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("t6_rst_state", 64'({busy, crc_valid, crc_bit, crc_clear, done}), 64'd0);
        check_eq("t6_rst_crc", 64'(crc_out), 64'd0);
        check_eq("t6_rst_bytes", 64'(byte_count), 64'd0);
        words = {32'hB888E3A7};
        snap();
        send_frame(1, 2'd0, 1'b0);
        wait_done(100);
        check_eq("t6_clear_cnt", 64'(clear_cnt - s_clear), 64'd1);
        check_eq("t6_crc", 64'(crc_out), 64'(crc_ref(4)));
        check_eq("t6_byte_count", 64'(byte_count), 64'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/crc32_frame_sequencer.md
Name: crc32_frame_sequencer

Overview:
Front-end controller for the bit-serial CRC_32_calculator core. It accepts a frame as 32-bit words over a valid/ready stream and clears the core at frame start. It then serializes each word MSB-first onto the core's clear/BITVAL/valid inputs. At frame end it latches the core's CRC, optionally complemented, and reports it with a done pulse. It sits between the Ethernet TX frame builder and the CRC core, and the FCS appender reads its result.

Parameters:
FINAL_XOR, 0, 1 = crc_out is the bitwise inverse of crc_in; 0 = crc_in passed raw
BYTE_CNT_W, 16, width of the frame byte counter

Ports:
clk  in  1  clock
rst_n  in  1  reset: synchronous, active-low
s_valid  in  1  input word valid
s_ready  out  1  word accepted when s_valid && s_ready
s_data  in  32  frame word; byte 0 = [31:24]; partial words are MSB-aligned
s_last  in  1  word is the final word of the frame
s_bytes  in  2  valid bytes in this word; 0 = 4 bytes, 1..3 = 1..3 bytes (only honoured when s_last)
abort  in  1  drop the current frame
crc_clear  out  1  to core clear
crc_bit  out  1  to core BITVAL
crc_valid  out  1  to core valid
crc_in  in  32  CRC from the core
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse; crc_out is valid in the same cycle
crc_out  out  32  latched frame CRC, held until the next done
byte_count  out  BYTE_CNT_W  bytes in the last completed frame, saturating

Behaviour:
- Reset (rst_n=0 at a clock edge) sets state IDLE and clears every output to 0, including crc_out, byte_count and the shift register. Reset overrides everything, including mid-frame.
- States and transitions:
  - IDLE -> CLEAR when s_valid=1. The word is not consumed.
  - CLEAR lasts 1 cycle with crc_clear=1, then goes to LOAD.
  - LOAD has s_ready=1. On handshake it loads shreg<=s_data and bitcnt<=8*bytes-1, where bytes = 4 if !s_last or s_bytes==0, else s_bytes. It also latches the last flag, adds bytes to the running count, and goes to SHIFT. With no s_valid it stays in LOAD, with crc_valid=0 and the core untouched.
  - SHIFT drives crc_valid=1 and crc_bit=shreg[31] every cycle, shifting shreg left by 1 and decrementing bitcnt. When bitcnt==0 it goes to WAIT if last, else to LOAD.
  - WAIT lasts 1 cycle with crc_valid=0, because the core's CRC lags the last bit by one edge. At its end it performs crc_out<=crc_in^{32{FINAL_XOR}}, sets byte_count to the running count and sets done<=1, then goes to DONE.
  - DONE lasts 1 cycle with done=1, then goes to IDLE.
- crc_clear, crc_bit and crc_valid are decoded from state/shreg only. s_ready is never combinationally dependent on s_valid.
- Timing: s_valid first seen in IDLE at cycle t gives CLEAR at t+1 and LOAD at t+2. A single full word then shifts in t+3..t+34, WAIT is t+35 and done is at t+36. Each additional word costs 1 LOAD cycle plus 8*bytes SHIFT cycles.
- The running byte counter resets in CLEAR and saturates at 2^BYTE_CNT_W-1.
- abort=1 in any non-IDLE state moves to IDLE next cycle. It forces s_ready=0 in that cycle, so abort wins over a simultaneous handshake. crc_valid is 0 from the next cycle, there is no done pulse, and crc_out/byte_count are unchanged. abort in IDLE is ignored.
- s_bytes is ignored when s_last=0, which always means a full word.

Decomposition:
- Package crc32_seq_pkg holds:
  - state enum {IDLE, CLEAR, LOAD, SHIFT, WAIT, DONE}
  - localparam CRC_W=32
  - function bytes_decode(s_last, s_bytes) returning 3 bits
- Sub-module crc32_word_serializer holds shreg, bitcnt, load/shift control and the `last bit` flag. The sequencer FSM stays in the top module.

Test Plan:
- Single word 32'hB888E3A7, s_last=1, s_bytes=0, idle at t: crc_clear high only at t+1; crc_valid high t+3..t+34 carrying bits 1,0,1,1,1,0,0,0,…; done at t+36; byte_count=4.
- Partial last word 32'h04020000, s_bytes=2, with a core model returning 32'h12345678 and FINAL_XOR=1: exactly 16 crc_valid cycles carrying 0x0402 MSB-first; crc_out=32'hEDCBA987; byte_count=2.
- 16 full words followed by 2-byte last word (0x0402 MSB-aligned), with s_valid always high: crc_valid asserted 528 cycles with a 1-cycle gap per LOAD; byte_count=66; crc_out equals the golden IEEE 802.3 CRC of the 66 bytes.
- s_valid deasserted for 5 cycles between words: FSM holds in LOAD, crc_valid=0 throughout, and the final CRC is identical to the no-gap run.
- abort after 10 SHIFT cycles, with abort and s_valid both high in LOAD: IDLE next cycle, no done, crc_out/byte_count keep prior values, word not accepted; a following frame produces the correct CRC.
- rst_n=0 mid-SHIFT for 1 cycle: all outputs 0 next cycle, state IDLE; the next frame starts with a fresh crc_clear.
